// File: rtl/cnn_pkg.sv
// +----------------------------------------------------------------------------+
// | cnn_pkg : shared geometry and en_counter codes for the conv/pool datapath.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package cnn_pkg;
    localparam int DATA_W   = 8;
    localparam int IN_W     = 28;
    localparam int CHANNELS = 6;
    localparam int POOL_W   = IN_W / 2;
    localparam int CNT_W    = $clog2(IN_W);
    localparam int K_W      = $clog2(POOL_W);
    localparam int CH_W     = $clog2(CHANNELS);
    localparam int LANES    = 8;
    localparam int LANE_W   = $clog2(LANES);
    localparam int WORD_W   = LANES * DATA_W;
    localparam int TAIL_W   = (POOL_W - LANES) * DATA_W;

    localparam logic [3:0] EN_IDLE   = 4'd0;
    localparam logic [3:0] EN_WORD64 = 4'd6;
    localparam logic [3:0] EN_WORD48 = 4'd8;

    function automatic logic [DATA_W-1:0] max_u(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction
endpackage

`default_nettype wire

// File: rtl/maxpool_pack_if.sv
// +----------------------------------------------------------------------------+
// | maxpool_pack_if : conv pixel input and packed pooled-word output bundle.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface maxpool_pack_if;
    import cnn_pkg::*;

    logic              conv_valid;
    logic [DATA_W-1:0] conv_data;
    logic              conv_ready;
    logic [WORD_W-1:0] pool_data;
    logic [3:0]        en_counter;
    logic              chan_done;
    logic              frame_done;

    modport master (
        output conv_valid, conv_data,
        input  conv_ready, pool_data, en_counter, chan_done, frame_done
    );

    modport slave (
        input  conv_valid, conv_data,
        output conv_ready, pool_data, en_counter, chan_done, frame_done
    );
endinterface

`default_nettype wire

// File: rtl/pool_line_buf.sv
// +----------------------------------------------------------------------------+
// | pool_line_buf : one pooled row of horizontal pair maxima, comb read port.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pool_line_buf
    import cnn_pkg::*;
#(
    parameter int DEPTH = POOL_W,
    parameter int WIDTH = DATA_W,
    parameter int IDX_W = K_W
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             clear,
    input  wire logic             wr_en,
    input  wire logic [IDX_W-1:0] wr_idx,
    input  wire logic [WIDTH-1:0] wr_data,
    input  wire logic [IDX_W-1:0] rd_idx,
    output logic      [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clear) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem[rd_idx];

endmodule

`default_nettype wire

// File: rtl/maxpool_pack.sv
// +----------------------------------------------------------------------------+
// | maxpool_pack : 2x2/stride-2 max-pool packing each pooled row as 8+6 bytes.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module maxpool_pack
    import cnn_pkg::*;
(
    input  wire logic      clk,
    input  wire logic      rst,
    input  wire logic      clear,
    maxpool_pack_if.slave  pif
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IN_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [K_W-1:0]   K_WORD64 = K_W'(LANES - 1);
    localparam logic [K_W-1:0]   K_WORD48 = K_W'(POOL_W - 1);

    logic [CNT_W-1:0]  col_cnt, row_cnt;
    logic [CH_W-1:0]   chan_cnt;
    logic [DATA_W-1:0] hold_px;
    logic [WORD_W-1:0] pack_word, pack_next;
    logic [WORD_W-1:0] pool_word;
    logic [3:0]        en_code;
    logic              chan_pulse, frame_flag;

    logic              accept;
    logic [K_W-1:0]    k_idx;
    logic [LANE_W-1:0] lane;
    logic [DATA_W-1:0] line_rd, pair_max, win_max;
    logic              odd_row, odd_col, row_last, chan_last, emit64, emit48;

    assign accept    = pif.conv_valid & ~frame_flag & ~clear;
    assign k_idx     = col_cnt[CNT_W-1:1];
    assign lane      = k_idx[LANE_W-1:0];
    assign odd_row   = row_cnt[0];
    assign odd_col   = col_cnt[0];
    assign row_last  = (row_cnt == ROW_LAST);
    assign chan_last = (chan_cnt == CH_LAST);
    assign pair_max  = max_u(hold_px, pif.conv_data);
    assign win_max   = max_u(line_rd, pair_max);
    assign emit64    = odd_row & odd_col & (k_idx == K_WORD64);
    assign emit48    = odd_row & odd_col & (k_idx == K_WORD48);

    pool_line_buf u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (accept & ~odd_row & odd_col),
        .wr_idx  (k_idx),
        .wr_data (pair_max),
        .rd_idx  (k_idx),
        .rd_data (line_rd)
    );

    always_comb begin
        pack_next = pack_word;
        pack_next[int'(lane) * DATA_W +: DATA_W] = win_max;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            chan_cnt   <= '0;
            hold_px    <= '0;
            pack_word  <= '0;
            pool_word  <= '0;
            en_code    <= EN_IDLE;
            chan_pulse <= 1'b0;
            frame_flag <= 1'b0;
        end else if (clear) begin
            col_cnt    <= '0;
            row_cnt    <= '0;
            chan_cnt   <= '0;
            hold_px    <= '0;
            pack_word  <= '0;
            pool_word  <= '0;
            en_code    <= EN_IDLE;
            chan_pulse <= 1'b0;
            frame_flag <= 1'b0;
        end else begin
            en_code    <= EN_IDLE;
            chan_pulse <= 1'b0;
            if (accept) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    if (row_last) begin
                        row_cnt  <= '0;
                        chan_cnt <= chan_last ? '0 : chan_cnt + 1'b1;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end

                if (!odd_col) hold_px <= pif.conv_data;

                // Only odd rows touch the pack; each word clears it once sent.
                if (emit64) begin
                    pool_word <= pack_next;
                    en_code   <= EN_WORD64;
                    pack_word <= '0;
                end else if (emit48) begin
                    pool_word  <= {{(WORD_W - TAIL_W){1'b0}}, pack_next[TAIL_W-1:0]};
                    en_code    <= EN_WORD48;
                    pack_word  <= '0;
                    chan_pulse <= row_last;
                    frame_flag <= row_last & chan_last;
                end else if (odd_row && odd_col) begin
                    pack_word <= pack_next;
                end
            end
        end
    end

    assign pif.conv_ready = ~frame_flag;
    assign pif.pool_data  = pool_word;
    assign pif.en_counter = en_code;
    assign pif.chan_done  = chan_pulse;
    assign pif.frame_done = frame_flag;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_pack.sv
// +----------------------------------------------------------------------------+
// | tb_maxpool_pack : scoreboard bench for the 2x2 max-pool packer.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_maxpool_pack;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clear = 1'b0;

    maxpool_pack_if pif();

    maxpool_pack dut (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .pif   (pif)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  en;
        logic [63:0] data;
        logic        cd;
        logic        fd;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    int   last6  = 0;
    int   cd_cnt = 0;
    bit   gap_en  = 1'b0;
    bit   gap_chk = 1'b1;
    logic [7:0] fr [CHANNELS][IN_W][IN_W];

    always @(posedge clk) cyc++;

    // Monitor: every presented word is popped and compared against the queue.
    always @(negedge clk) begin
        exp_t act, e;
        if (!rst) begin
            act = {pif.en_counter, pif.pool_data, pif.chan_done, pif.frame_done};
            if (pif.chan_done) cd_cnt++;
            if (pif.en_counter != 4'd0) begin
                checks++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL emit_unexpected: got en=%0d data=%h, required no word", pif.en_counter, pif.pool_data);
                end else begin
                    e = sb.pop_front();
                    if (act !== e) begin
                        fails++;
                        $display("FAIL word: got en=%0d data=%h cd=%b fd=%b, required en=%0d data=%h cd=%b fd=%b",
                                 act.en, act.data, act.cd, act.fd, e.en, e.data, e.cd, e.fd);
                    end
                end
                if (gap_chk && pif.en_counter == EN_WORD48) begin
                    checks++;
                    if (cyc - last6 != 12) begin
                        fails++;
                        $display("FAIL word_gap: got %0d cycles, required 12", cyc - last6);
                    end
                end
                if (pif.en_counter == EN_WORD64) last6 = cyc;
            end else if (pif.chan_done) begin
                checks++;
                fails++;
                $display("FAIL stray_chan_done: got 1 without word, required 0");
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, "_data"}, pif.pool_data, 64'd0);
        chk({name, "_ctl"}, {57'd0, pif.en_counter, pif.chan_done, pif.frame_done, pif.conv_ready},
            {57'd0, 4'd0, 1'b0, 1'b0, 1'b1});
    endtask

    function automatic logic [63:0] model_word(input int ch, input int r, input int k);
        logic [63:0] w = '0;
        logic [7:0]  m;
        int base = (k == LANES - 1) ? 0 : LANES;
        int n    = (k == LANES - 1) ? LANES : POOL_W - LANES;
        for (int j = 0; j < n; j++) begin
            m = fr[ch][r-1][2*(base+j)];
            if (fr[ch][r-1][2*(base+j)+1] > m) m = fr[ch][r-1][2*(base+j)+1];
            if (fr[ch][r][2*(base+j)] > m)     m = fr[ch][r][2*(base+j)];
            if (fr[ch][r][2*(base+j)+1] > m)   m = fr[ch][r][2*(base+j)+1];
            w[8*j +: 8] = m;
        end
        return w;
    endfunction

    task automatic send_px(input int ch, input int r, input int c, input logic [7:0] v, input bit auto_exp);
        exp_t e;
        int   k = c / 2;
        int   n = 0;
        if (gap_en) begin
            while ($urandom_range(1, 0) == 1 && n < 8) begin
                pif.conv_valid = 1'b0;
                tick();
                n++;
            end
        end
        if (auto_exp && (r % 2 == 1) && (c % 2 == 1) && (k == LANES - 1 || k == POOL_W - 1)) begin
            e.en   = (k == LANES - 1) ? EN_WORD64 : EN_WORD48;
            e.data = model_word(ch, r, k);
            e.cd   = (k == POOL_W - 1) && (r == IN_W - 1);
            e.fd   = e.cd && (ch == CHANNELS - 1);
            sb.push_back(e);
        end
        pif.conv_valid = 1'b1;
        pif.conv_data  = v;
        tick();
    endtask

    task automatic run_frame(input int sc, input int sr, input int scol);
        for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < IN_W; r++)
                for (int c = 0; c < IN_W; c++) begin
                    if (ch == sc && r == sr && c == scol) return;
                    send_px(ch, r, c, fr[ch][r][c], 1'b1);
                end
        pif.conv_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        pif.conv_valid = 1'b0;
        while (sb.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        chk({name, "_drain"}, 64'(sb.size()), 64'd0);
        sb.delete();
        tick();
        tick();
    endtask

    task automatic do_clear(input string name);
        pif.conv_valid = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cd_cnt = 0;
        check_idle(name);
    endtask

    task automatic fill_rand();
        for (int ch = 0; ch < CHANNELS; ch++)
            for (int r = 0; r < IN_W; r++)
                for (int c = 0; c < IN_W; c++)
                    fr[ch][r][c] = 8'($urandom_range(255, 0));
    endtask

    initial begin
        exp_t e;
        pif.conv_valid = 1'b0;
        pif.conv_data  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("reset");
        rst = 1'b0;
        tick();

        // Ramp on rows 0/1 of channel 0 with hand-computed words.
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IN_W; c++)
                fr[0][r][c] = 8'((r * IN_W + c) & 255);
        e = {EN_WORD64, 64'h2B29_2725_2321_1F1D, 1'b0, 1'b0}; sb.push_back(e);
        e = {EN_WORD48, 64'h0000_3735_3331_2F2D, 1'b0, 1'b0}; sb.push_back(e);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < IN_W; c++)
                send_px(0, r, c, fr[0][r][c], 1'b0);
        drain("ramp");
        do_clear("clear_after_ramp");

        // Single FF in each position of window k=3.
        for (int p = 0; p < 4; p++) begin
            e = {EN_WORD64, 64'h0000_0000_FF00_0000, 1'b0, 1'b0}; sb.push_back(e);
            e = {EN_WORD48, 64'h0, 1'b0, 1'b0};                   sb.push_back(e);
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < IN_W; c++)
                    send_px(0, r, c, (r == (p >> 1) && c == 6 + (p & 1)) ? 8'hFF : 8'h00, 1'b0);
            drain("maxpos");
            do_clear("clear_after_maxpos");
        end

        // Full random frame, continuous valid.
        fill_rand();
        run_frame(-1, 0, 0);
        drain("frame");
        chk("frame_chan_done_count", 64'(cd_cnt), 64'd6);
        chk("frame_done_state", {62'd0, pif.conv_ready, pif.frame_done}, 64'b01);

        // Pixels offered after frame_done must be ignored.
        for (int i = 0; i < 10; i++) send_px(0, 1, 1, 8'hFF, 1'b0);
        drain("after_done");
        chk("after_done_state", {62'd0, pif.conv_ready, pif.frame_done}, 64'b01);
        do_clear("clear_after_frame");

        // Same frame with random valid gaps.
        gap_en  = 1'b1;
        gap_chk = 1'b0;
        run_frame(-1, 0, 0);
        drain("gapped");
        chk("gapped_chan_done_count", 64'(cd_cnt), 64'd6);
        gap_en  = 1'b0;
        gap_chk = 1'b1;
        do_clear("clear_after_gapped");

        // clear mid-frame with a pixel offered in the same cycle.
        fill_rand();
        run_frame(2, 5, 20);
        pif.conv_valid = 1'b1;
        pif.conv_data  = 8'hFF;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        pif.conv_valid = 1'b0;
        check_idle("clear_mid");
        chk("clear_mid_queue", 64'(sb.size()), 64'd0);
        cd_cnt = 0;
        fill_rand();
        run_frame(-1, 0, 0);
        drain("after_clear_mid");
        chk("after_clear_mid_chan_done_count", 64'(cd_cnt), 64'd6);
        do_clear("clear_before_rst_test");

        // Asynchronous rst mid-frame.
        fill_rand();
        run_frame(3, 11, 20);
        pif.conv_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_idle("rst_mid");
        tick();
        rst = 1'b0;
        tick();
        sb.delete();
        cd_cnt = 0;
        fill_rand();
        run_frame(-1, 0, 0);
        drain("after_rst_mid");
        chk("after_rst_mid_chan_done_count", 64'(cd_cnt), 64'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

`default_nettype wire
